// File: rtl/lc3_mem_if.sv
// LC-3 memory interface: MAR/MDR pair, access sequencer towards external
// memory, and the memory-mapped keyboard/display device registers.
module lc3_mem_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        gate_mdr,
  inout  wire  [15:0] data_bus,
  output logic        ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack
);

  typedef enum logic [1:0] {IDLE, MEM, DEV, DONE} state_t;

  state_t      state;
  logic [15:0] mar, mdr;
  logic        armed, op;

  // device register state; only the meaningful bits are stored
  logic        kbsr_f, dsr_f;
  logic [7:0]  kbdr, ddr;

  logic        dev_hit;
  logic [1:0]  sel;
  logic [15:0] dev_rdata;
  logic        kbdr_rd, ddr_wr;

  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign disp_data = ddr;
  assign data_bus  = gate_mdr ? mdr : 16'bz;

  // device decode: even addresses in xFE00..xFE07, MAR[2:1] picks the register
  always_comb begin
    dev_hit   = (mar[15:3] == 13'h1FC0) && !mar[0];
    sel       = mar[2:1];
    dev_rdata = 16'h0000;
    case (sel)
      2'd0: dev_rdata = {kbsr_f, 15'b0};
      2'd1: dev_rdata = {8'b0, kbdr};
      2'd2: dev_rdata = {dsr_f, 15'b0};
      2'd3: dev_rdata = {8'b0, ddr};
      default: dev_rdata = 16'h0000;
    endcase
    kbdr_rd = (state == DEV) && !op && (sel == 2'd1);
    // a DDR write while the display is busy is silently dropped
    ddr_wr  = (state == DEV) && op && (sel == 2'd3) && dsr_f;
  end

  // access sequencer; MAR/MDR only accept bus loads while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mar    <= 16'h0000;
      mdr    <= 16'h0000;
      armed  <= 1'b1;
      op     <= 1'b0;
      ready  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      // re-arm only after mio_en drops, so a held request starts one access
      if (!mio_en) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (ld_mar) mar <= data_bus;
          if (ld_mdr && !mio_en) mdr <= data_bus;
          if (mio_en && armed) begin
            armed <= 1'b0;
            op    <= r_w;
            if (dev_hit) begin
              state <= DEV;
            end else begin
              state  <= MEM;
              mem_en <= 1'b1;
              mem_we <= r_w;
            end
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (!op) mdr <= mem_rdata;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            ready  <= 1'b1;
            state  <= DONE;
          end
        end
        DEV: begin
          if (!op) mdr <= dev_rdata;
          ready <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // keyboard and display status/data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kbsr_f     <= 1'b0;
      kbdr       <= 8'h00;
      dsr_f      <= 1'b1;
      ddr        <= 8'h00;
      disp_valid <= 1'b0;
    end else begin
      // a new character wins over the read-clear of the same cycle
      if (kb_valid) begin
        kbsr_f <= 1'b1;
        kbdr   <= kb_data;
      end else if (kbdr_rd) begin
        kbsr_f <= 1'b0;
      end
      // ddr_wr needs dsr_f=1, which implies disp_valid=0, so no overlap with ack
      if (ddr_wr) begin
        ddr        <= mdr[7:0];
        dsr_f      <= 1'b0;
        disp_valid <= 1'b1;
      end else if (disp_ack && disp_valid) begin
        disp_valid <= 1'b0;
        dsr_f      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_if.sv
// Directed bench for lc3_mem_if: reset, external read/write, load blocking,
// keyboard and display device registers.
module tb_lc3_mem_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_mar, ld_mdr, mio_en, r_w, gate_mdr;
  wire  [15:0] data_bus;
  logic        ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, mem_ready;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ack;

  logic        bus_en;
  logic [15:0] bus_val;

  int total = 0;
  int passed = 0;

  assign data_bus = bus_en ? bus_val : 16'bz;

  always #5 clk = ~clk;

  lc3_mem_if dut (
    .clk(clk), .rst(rst), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en),
    .r_w(r_w), .gate_mdr(gate_mdr), .data_bus(data_bus), .ready(ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_ready(mem_ready),
    .kb_valid(kb_valid), .kb_data(kb_data), .disp_valid(disp_valid),
    .disp_data(disp_data), .disp_ack(disp_ack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mar(input logic [15:0] v);
    bus_en = 1'b1; bus_val = v; ld_mar = 1'b1;
    tick;
    ld_mar = 1'b0; bus_en = 1'b0;
  endtask

  task automatic set_mdr(input logic [15:0] v);
    bus_en = 1'b1; bus_val = v; ld_mdr = 1'b1;
    tick;
    ld_mdr = 1'b0; bus_en = 1'b0;
  endtask

  // device access; optional keyboard strobe (x43) coincident with the DEV cycle
  task automatic dev_acc(input logic [15:0] a, input logic rw, input logic kb_during,
                         output logic rdy);
    set_mar(a);
    r_w = rw; mio_en = 1'b1;
    tick;
    mio_en = 1'b0;
    if (kb_during) begin kb_valid = 1'b1; kb_data = 8'h43; end
    tick;
    kb_valid = 1'b0;
    rdy = ready;
    tick;
  endtask

  task automatic test_reset;
    int pulses;
    logic rdy;
    total++; if (mem_addr !== 16'h0) $display("FAIL reset_mar got %h exp 0000", mem_addr); else passed++;
    total++; if (mem_wdata !== 16'h0) $display("FAIL reset_mdr got %h exp 0000", mem_wdata); else passed++;
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_mem_en got %b%b exp 00", mem_en, mem_we); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else passed++;
    total++; if (disp_valid !== 1'b0 || disp_data !== 8'h0) $display("FAIL reset_disp got %b/%h exp 0/00", disp_valid, disp_data); else passed++;
    // bus must be released: a value driven by the bench loads MAR intact
    set_mar(16'h5A5A);
    total++; if (mem_addr !== 16'h5A5A) $display("FAIL reset_bus_z got %h exp 5a5a", mem_addr); else passed++;
    dev_acc(16'hFE04, 1'b0, 1'b0, rdy);
    total++; if (mem_wdata !== 16'h8000) $display("FAIL reset_dsr got %h exp 8000", mem_wdata); else passed++;
    // reset in the middle of a stalled external access
    set_mar(16'h3000);
    mem_ready = 1'b0; r_w = 1'b0; mio_en = 1'b1;
    tick;
    mio_en = 1'b0;
    total++; if (mem_en !== 1'b1) $display("FAIL midrst_mem_en_before got %b exp 1", mem_en); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (mem_en !== 1'b0 || mem_addr !== 16'h0) $display("FAIL midrst_async got en=%b addr=%h exp en=0 addr=0000", mem_en, mem_addr); else passed++;
    pulses = 0;
    tick; if (ready) pulses++;
    rst = 1'b1;
    repeat (4) begin tick; if (ready || mem_en) pulses++; end
    total++; if (pulses != 0) $display("FAIL midrst_no_ready got %0d pulses exp 0", pulses); else passed++;
  endtask

  task automatic test_ext_read;
    int en_cnt, cyc;
    set_mar(16'h3000);
    mem_rdata = 16'h1234; mem_ready = 1'b0; r_w = 1'b0; mio_en = 1'b1;
    tick;
    mio_en = 1'b0;
    en_cnt = 0; cyc = 0;
    while (!ready && cyc < 10) begin
      if (mem_en) en_cnt++;
      mem_ready = (en_cnt == 3);
      tick;
      cyc++;
    end
    mem_ready = 1'b0;
    total++; if (en_cnt != 3) $display("FAIL rd_mem_en_cycles got %0d exp 3", en_cnt); else passed++;
    total++; if (cyc != 3 || ready !== 1'b1) $display("FAIL rd_ready_timing got cyc=%0d ready=%b exp cyc=3 ready=1", cyc, ready); else passed++;
    total++; if (mem_wdata !== 16'h1234 || mem_en !== 1'b0) $display("FAIL rd_mdr got %h en=%b exp 1234 en=0", mem_wdata, mem_en); else passed++;
    tick;
    total++; if (ready !== 1'b0) $display("FAIL rd_ready_pulse got %b exp 0", ready); else passed++;
    gate_mdr = 1'b1;
    #1;
    total++; if (data_bus !== 16'h1234) $display("FAIL rd_gate_mdr got %h exp 1234", data_bus); else passed++;
    gate_mdr = 1'b0;
    tick;
  endtask

  task automatic test_ext_write;
    int en_cnt, cyc, extra;
    logic ok;
    set_mar(16'h4000);
    set_mdr(16'hBEEF);
    r_w = 1'b1; mio_en = 1'b1;
    tick;
    en_cnt = 0; cyc = 0; ok = 1'b1;
    while (!ready && cyc < 10) begin
      if (mem_en) begin
        en_cnt++;
        if (mem_we !== 1'b1 || mem_wdata !== 16'hBEEF || mem_addr !== 16'h4000) ok = 1'b0;
      end
      mem_ready = (en_cnt == 2);
      tick;
      cyc++;
    end
    mem_ready = 1'b0;
    total++; if (ready !== 1'b1 || en_cnt != 2) $display("FAIL wr_access got ready=%b en=%0d exp ready=1 en=2", ready, en_cnt); else passed++;
    total++; if (!ok) $display("FAIL wr_we_wdata got we=%b wdata=%h exp we=1 wdata=beef", mem_we, mem_wdata); else passed++;
    total++; if (mem_wdata !== 16'hBEEF || mem_addr !== 16'h4000) $display("FAIL wr_done_stable got %h/%h exp 4000/beef", mem_addr, mem_wdata); else passed++;
    extra = 0;
    repeat (5) begin tick; if (mem_en || ready) extra++; end
    mio_en = 1'b0;
    total++; if (extra != 0) $display("FAIL wr_held_mio got %0d extra cycles exp 0", extra); else passed++;
    tick;
  endtask

  task automatic test_load_block;
    set_mar(16'h5000);
    set_mdr(16'hAAAA);
    r_w = 1'b1; mio_en = 1'b1; mem_ready = 1'b0;
    tick;
    mio_en = 1'b0;
    bus_en = 1'b1; bus_val = 16'h1111; ld_mar = 1'b1; ld_mdr = 1'b1;
    tick;
    ld_mar = 1'b0; ld_mdr = 1'b0; bus_en = 1'b0;
    total++; if (mem_addr !== 16'h5000 || mem_wdata !== 16'hAAAA) $display("FAIL blk_mid got %h/%h exp 5000/aaaa", mem_addr, mem_wdata); else passed++;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    total++; if (ready !== 1'b1 || mem_addr !== 16'h5000) $display("FAIL blk_done got ready=%b addr=%h exp 1/5000", ready, mem_addr); else passed++;
    tick;
    // odd address in device window goes to external memory
    set_mar(16'hFE01);
    r_w = 1'b0; mio_en = 1'b1;
    tick;
    mio_en = 1'b0;
    total++; if (mem_en !== 1'b1) $display("FAIL odd_addr_mem got en=%b exp 1", mem_en); else passed++;
    mem_rdata = 16'hCAFE; mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    total++; if (mem_wdata !== 16'hCAFE || ready !== 1'b1) $display("FAIL odd_addr_data got %h ready=%b exp cafe 1", mem_wdata, ready); else passed++;
    tick;
  endtask

  task automatic test_keyboard;
    logic rdy;
    kb_valid = 1'b1; kb_data = 8'h41;
    tick;
    kb_valid = 1'b0;
    dev_acc(16'hFE00, 1'b0, 1'b0, rdy);
    total++; if (mem_wdata !== 16'h8000 || rdy !== 1'b1) $display("FAIL kb_kbsr_set got %h rdy=%b exp 8000 1", mem_wdata, rdy); else passed++;
    dev_acc(16'hFE02, 1'b0, 1'b0, rdy);
    total++; if (mem_wdata !== 16'h0041) $display("FAIL kb_kbdr got %h exp 0041", mem_wdata); else passed++;
    dev_acc(16'hFE00, 1'b0, 1'b0, rdy);
    total++; if (mem_wdata !== 16'h0000) $display("FAIL kb_kbsr_clr got %h exp 0000", mem_wdata); else passed++;
    kb_valid = 1'b1; kb_data = 8'h42;
    tick;
    kb_valid = 1'b0;
    dev_acc(16'hFE02, 1'b0, 1'b1, rdy);
    total++; if (mem_wdata !== 16'h0042) $display("FAIL kb_coinc_old got %h exp 0042", mem_wdata); else passed++;
    dev_acc(16'hFE00, 1'b0, 1'b0, rdy);
    total++; if (mem_wdata !== 16'h8000) $display("FAIL kb_coinc_kbsr got %h exp 8000", mem_wdata); else passed++;
    dev_acc(16'hFE02, 1'b0, 1'b0, rdy);
    total++; if (mem_wdata !== 16'h0043) $display("FAIL kb_coinc_new got %h exp 0043", mem_wdata); else passed++;
  endtask

  task automatic test_display;
    logic rdy;
    set_mdr(16'h0058);
    dev_acc(16'hFE06, 1'b1, 1'b0, rdy);
    total++; if (disp_valid !== 1'b1 || disp_data !== 8'h58 || rdy !== 1'b1) $display("FAIL disp_write got v=%b d=%h rdy=%b exp 1/58/1", disp_valid, disp_data, rdy); else passed++;
    dev_acc(16'hFE04, 1'b0, 1'b0, rdy);
    total++; if (mem_wdata !== 16'h0000) $display("FAIL disp_dsr_busy got %h exp 0000", mem_wdata); else passed++;
    set_mdr(16'h0059);
    dev_acc(16'hFE06, 1'b1, 1'b0, rdy);
    total++; if (disp_data !== 8'h58 || disp_valid !== 1'b1) $display("FAIL disp_drop got %h v=%b exp 58 1", disp_data, disp_valid); else passed++;
    dev_acc(16'hFE06, 1'b0, 1'b0, rdy);
    total++; if (mem_wdata !== 16'h0058) $display("FAIL disp_ddr_read got %h exp 0058", mem_wdata); else passed++;
    disp_ack = 1'b1;
    tick;
    disp_ack = 1'b0;
    total++; if (disp_valid !== 1'b0) $display("FAIL disp_ack_valid got %b exp 0", disp_valid); else passed++;
    dev_acc(16'hFE04, 1'b0, 1'b0, rdy);
    total++; if (mem_wdata !== 16'h8000) $display("FAIL disp_dsr_idle got %h exp 8000", mem_wdata); else passed++;
  endtask

  initial begin
    rst = 1'b0;
    ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0; gate_mdr = 1'b0;
    mem_rdata = 16'h0; mem_ready = 1'b0; kb_valid = 1'b0; kb_data = 8'h0;
    disp_ack = 1'b0; bus_en = 1'b0; bus_val = 16'h0;
    repeat (2) tick;
    rst = 1'b1;
    tick;
    test_reset;
    test_ext_read;
    test_ext_write;
    test_load_block;
    test_keyboard;
    test_display;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
